// File: rtl/edge_debounce_pkg.sv
// Shared types and default widths for the edge debouncer slice.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_L2H  = 2'd1,
        S_HIGH = 2'd2,
        S_H2L  = 2'd3
    } debounce_state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int GLITCH_W_DEF = 8;

endpackage

// File: rtl/edge_debounce_if.sv
// Control/status bundle between the edge-detector side and the debouncer.
interface edge_debounce_if
    import debounce_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int GLITCH_W = GLITCH_W_DEF
) ();

    logic                en_i;
    logic                sig_i;
    logic                re_i;
    logic                fe_i;
    logic [CNT_W-1:0]    cnt_max_i;
    logic                glitch_clr_i;
    logic                irq_clr_i;
    logic                level_o;
    logic                rise_o;
    logic                fall_o;
    logic                busy_o;
    logic [GLITCH_W-1:0] glitch_cnt_o;
    logic                irq_o;

    modport master (
        output en_i, sig_i, re_i, fe_i, cnt_max_i, glitch_clr_i, irq_clr_i,
        input  level_o, rise_o, fall_o, busy_o, glitch_cnt_o, irq_o
    );

    modport slave (
        input  en_i, sig_i, re_i, fe_i, cnt_max_i, glitch_clr_i, irq_clr_i,
        output level_o, rise_o, fall_o, busy_o, glitch_cnt_o, irq_o
    );

endinterface

// File: rtl/edge_debounce_sat_counter.sv
// Saturating up-counter with selectable clear/increment priority.
module sat_counter #(
    parameter int WIDTH    = 8,
    parameter bit CLR_PRIO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr && !(inc && !CLR_PRIO)) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/edge_debounce.sv
// Debounces a synchronised level by requiring cnt_max_i+1 stable cycles per change.
// Optional pending-interrupt flag enabled by defining EDGE_DEBOUNCE_IRQ_EN.
module edge_debounce
    import debounce_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int GLITCH_W = GLITCH_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    edge_debounce_if.slave bus
);

    debounce_state_e  state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;
    logic             glitch_inc;

    // Aborts are decoded combinationally so the glitch count moves on the same edge.
    always_comb begin
        glitch_inc = 1'b0;
        if (bus.en_i && state == S_L2H && (!bus.sig_i || bus.fe_i)) glitch_inc = 1'b1;
        if (bus.en_i && state == S_H2L && (bus.sig_i || bus.re_i))  glitch_inc = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_LOW;
            cnt         <= '0;
            thr         <= '0;
            bus.level_o <= 1'b0;
            bus.rise_o  <= 1'b0;
            bus.fall_o  <= 1'b0;
            bus.busy_o  <= 1'b0;
        end else begin
            bus.rise_o <= 1'b0;
            bus.fall_o <= 1'b0;
            if (!bus.en_i) begin
                state       <= bus.sig_i ? S_HIGH : S_LOW;
                cnt         <= '0;
                bus.level_o <= bus.sig_i;
                bus.busy_o  <= 1'b0;
            end else begin
                unique case (state)
                    S_LOW: if (bus.re_i) begin
                        state      <= S_L2H;
                        cnt        <= '0;
                        thr        <= bus.cnt_max_i;
                        bus.busy_o <= 1'b1;
                    end
                    S_HIGH: if (bus.fe_i) begin
                        state      <= S_H2L;
                        cnt        <= '0;
                        thr        <= bus.cnt_max_i;
                        bus.busy_o <= 1'b1;
                    end
                    S_L2H: begin
                        if (!bus.sig_i || bus.fe_i) begin
                            state      <= S_LOW;
                            bus.busy_o <= 1'b0;
                        end else if (cnt == thr) begin
                            state       <= S_HIGH;
                            bus.rise_o  <= 1'b1;
                            bus.level_o <= 1'b1;
                            bus.busy_o  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_H2L: begin
                        if (bus.sig_i || bus.re_i) begin
                            state      <= S_HIGH;
                            bus.busy_o <= 1'b0;
                        end else if (cnt == thr) begin
                            state       <= S_LOW;
                            bus.fall_o  <= 1'b1;
                            bus.level_o <= 1'b0;
                            bus.busy_o  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_LOW;
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH    (GLITCH_W),
        .CLR_PRIO (1'b1)
    ) u_glitch_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (glitch_inc),
        .clr   (bus.glitch_clr_i),
        .count (bus.glitch_cnt_o)
    );

`ifdef EDGE_DEBOUNCE_IRQ_EN
    // Set is driven by the registered pulses, so a clear landing in the pulse cycle loses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.irq_o <= 1'b0;
        end else if (bus.rise_o || bus.fall_o) begin
            bus.irq_o <= 1'b1;
        end else if (bus.irq_clr_i) begin
            bus.irq_o <= 1'b0;
        end
    end
`else
    logic irq_clr_unused;
    assign irq_clr_unused = bus.irq_clr_i;
    assign bus.irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_edge_debounce.sv
// Scoreboard bench: a timing-based reference model pushes expected outputs per edge,
// a monitor pops and compares them on the falling edge.
module tb_edge_debounce;

    localparam int CNT_W    = 16;
    localparam int GLITCH_W = 2;
    localparam int GMAX     = (1 << GLITCH_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_debounce_if #(.CNT_W(CNT_W), .GLITCH_W(GLITCH_W)) bus ();

    edge_debounce #(.CNT_W(CNT_W), .GLITCH_W(GLITCH_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic                level;
        logic                rise;
        logic                fall;
        logic                busy;
        logic                irq;
        logic [GLITCH_W-1:0] gl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_sig = 1'b0;

    // Model: a qualification started at edge q_start with threshold q_thr
    // completes at edge q_start+q_thr+1 unless an abort condition is seen first.
    int   edge_no = 0;
    logic m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0, m_irq = 1'b0;
    int   m_gl = 0;
    logic q_dir = 1'b0;
    int   q_start = 0, q_thr = 0;

    task automatic model_step();
        logic inc;
        exp_t e;
        edge_no++;
        inc = 1'b0;
        if (rst) begin
            m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
            m_irq = 1'b0; m_gl = 0;
        end else begin
`ifdef EDGE_DEBOUNCE_IRQ_EN
            if (m_rise || m_fall) m_irq = 1'b1;
            else if (bus.irq_clr_i) m_irq = 1'b0;
`endif
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (!bus.en_i) begin
                m_busy  = 1'b0;
                m_level = bus.sig_i;
            end else if (m_busy) begin
                if (q_dir ? (!bus.sig_i || bus.fe_i) : (bus.sig_i || bus.re_i)) begin
                    m_busy = 1'b0;
                    inc    = 1'b1;
                end else if (edge_no - q_start == q_thr + 1) begin
                    m_busy  = 1'b0;
                    m_level = q_dir;
                    if (q_dir) m_rise = 1'b1;
                    else       m_fall = 1'b1;
                end
            end else if (m_level ? bus.fe_i : bus.re_i) begin
                m_busy  = 1'b1;
                q_dir   = !m_level;
                q_start = edge_no;
                q_thr   = int'(bus.cnt_max_i);
            end
            if (bus.glitch_clr_i) m_gl = 0;
            else if (inc && m_gl < GMAX) m_gl++;
        end
        e.level = m_level; e.rise = m_rise; e.fall = m_fall;
        e.busy  = m_busy;  e.irq  = m_irq;  e.gl   = GLITCH_W'(m_gl);
        sb.push_back(e);
    endtask

    // Pulses are derived from the level, as the upstream edge detector would.
    task automatic tick(input logic s);
        bus.sig_i = s;
        bus.re_i  = s & ~prev_sig;
        bus.fe_i  = ~s & prev_sig;
        prev_sig  = s;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("level", 8'(bus.level_o), 8'(e.level));
                chk("rise",  8'(bus.rise_o),  8'(e.rise));
                chk("fall",  8'(bus.fall_o),  8'(e.fall));
                chk("busy",  8'(bus.busy_o),  8'(e.busy));
                chk("irq",   8'(bus.irq_o),   8'(e.irq));
                chk("glitch_cnt", 8'(bus.glitch_cnt_o), 8'(e.gl));
            end
        end
    end

    initial begin
        logic s;
        int   hold;
        s = 1'b0;
        hold = 0;
        bus.en_i = 1'b1; bus.cnt_max_i = CNT_W'(3);
        bus.glitch_clr_i = 1'b0; bus.irq_clr_i = 1'b0;
        bus.sig_i = 1'b0; bus.re_i = 1'b0; bus.fe_i = 1'b0;

        rst = 1'b1; tick(0); tick(0); rst = 1'b0;

        // clean rise then clean fall, N=3
        repeat (3) tick(0);
        repeat (8) tick(1);
        repeat (6) tick(0);

        // glitch rejected, N=5
        bus.cnt_max_i = CNT_W'(5);
        repeat (3) tick(1);
        repeat (4) tick(0);

        // threshold latched at entry
        bus.cnt_max_i = CNT_W'(4);
        repeat (3) tick(1);
        bus.cnt_max_i = CNT_W'(100);
        repeat (6) tick(1);
        bus.cnt_max_i = CNT_W'(2);
        repeat (5) tick(0);

        // saturation, then clear racing a sixth glitch
        bus.cnt_max_i = CNT_W'(5);
        repeat (5) begin tick(1); tick(1); tick(0); tick(0); end
        tick(1); tick(1);
        bus.glitch_clr_i = 1'b1; tick(0);
        bus.glitch_clr_i = 1'b0; tick(0);

        // bypass, then reset mid-qualification
        bus.en_i = 1'b0;
        repeat (12) tick(1'($urandom_range(0, 1)));
        tick(0);
        bus.en_i = 1'b1;
        bus.cnt_max_i = CNT_W'(10);
        tick(0);
        repeat (5) tick(1);
        rst = 1'b1; tick(1); rst = 1'b0;
        repeat (3) tick(1);
        repeat (2) tick(0);

        // irq: fall, then clear coinciding with the next rise pulse
        bus.cnt_max_i = CNT_W'(1);
        repeat (4) tick(1);
        repeat (5) tick(0);
        for (int i = 0; i < 20 && !m_rise; i++) tick(1);
        bus.irq_clr_i = 1'b1; tick(1);
        bus.irq_clr_i = 1'b0; tick(1);
        bus.irq_clr_i = 1'b1; tick(1);
        bus.irq_clr_i = 1'b0; tick(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                s    = ~s;
                hold = $urandom_range(0, 12);
            end else begin
                hold--;
            end
            bus.en_i = ($urandom_range(0, 99) >= 4);
            if ($urandom_range(0, 15) == 0) bus.cnt_max_i = CNT_W'($urandom_range(0, 6));
            bus.glitch_clr_i = bus.en_i && ($urandom_range(0, 63) == 0);
            bus.irq_clr_i    = ($urandom_range(0, 3) == 0);
            rst              = ($urandom_range(0, 299) == 0);
            tick(s);
        end
        rst = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edge_debounce.md
Name: edge_debounce

Overview:
- Stage directly downstream of the synchronising edge detector.
- Consumes its synchronised level and its one-cycle rise/fall pulses.
- Qualifies each level change by requiring the level to stay stable for a programmable number of cycles, then emits a clean debounced level and debounced edge pulses.
- Feeds GPIO/key interrupt logic; counts rejected glitches for software diagnostics.

Parameters:
- CNT_W, 16, width of the stability counter and of cnt_max_i.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  1 = debounce active, 0 = bypass
- sig_i  in  1  synchronised level from edge detector
- re_i  in  1  one-cycle rising-edge pulse from edge detector
- fe_i  in  1  one-cycle falling-edge pulse from edge detector
- cnt_max_i  in  CNT_W  stability threshold N, in cycles
- glitch_clr_i  in  1  clear glitch counter
- irq_clr_i  in  1  clear pending interrupt
- level_o  out  1  debounced level
- rise_o  out  1  one-cycle debounced rising pulse
- fall_o  out  1  one-cycle debounced falling pulse
- busy_o  out  1  qualification in progress
- glitch_cnt_o  out  GLITCH_W  rejected-transition count
- irq_o  out  1  pending interrupt

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high: clk_i, rst_i.
- Reset values: state S_LOW, level_o=0, rise_o=0, fall_o=0, busy_o=0, glitch_cnt_o=0, irq_o=0, counter=0.
- All outputs are registered.
- FSM states: S_LOW, S_L2H, S_HIGH, S_H2L.
  - S_LOW: on re_i go to S_L2H; counter:=0; latch cnt_max_i into thr.
  - S_HIGH: on fe_i go to S_H2L; counter:=0; latch cnt_max_i into thr.
  - S_L2H: if sig_i==0 or fe_i, abort to S_LOW and increment the glitch count. Else if counter==thr, go to S_HIGH and pulse rise_o. Else counter++.
  - S_H2L: mirror of S_L2H. Abort condition is sig_i==1 or re_i. Completion goes to S_LOW and pulses fall_o.
- Latency: re_i sampled at edge T with sig_i stable high gives rise_o=1 and level_o=1 in cycle T+2+N. N=0 gives T+2.
- thr is latched at qualification entry. Changing cnt_max_i mid-qualification has no effect until the next qualification.
- re_i seen in S_HIGH or S_L2H, and fe_i seen in S_LOW or S_H2L, are ignored. The abort rules above take precedence.
- busy_o=1 exactly while the state is S_L2H or S_H2L.
- Counter never wraps: it stops at thr, and thr is at most 2^CNT_W-1.
- Glitch counter saturates at 2^GLITCH_W-1. glitch_clr_i zeroes it; if clear and increment occur in the same cycle, clear wins.
- en_i=0 (bypass):
  - Next state is S_HIGH if sig_i, else S_LOW.
  - Counter is cleared; level_o follows sig_i with 1-cycle latency.
  - rise_o and fall_o are held 0; glitch count is frozen.
- en_i deasserted mid-qualification aborts without a pulse and without a glitch increment.
- rst_i mid-qualification returns everything to reset values; no pulse is emitted.

Optional Feature:
- Macro: EDGE_DEBOUNCE_IRQ_EN.
- Defined:
  - irq_o sets on any rise_o or fall_o.
  - irq_o clears on irq_clr_i.
  - Set and clear in the same cycle: set wins.
- Undefined: irq_o is tied to 0 and irq_clr_i is ignored.

Decomposition:
- Shared package debounce_pkg holds:
  - typedef enum logic [1:0] debounce_state_e {S_LOW, S_L2H, S_HIGH, S_H2L}
  - localparam defaults for CNT_W and GLITCH_W
- One natural sub-module, sat_counter (parameterised width, inc, clr, clr priority), used for the glitch counter.

Test Plan:
- Clean rise: N=3, sig_i rises, re_i pulse at cycle 10, sig_i held high. Expect busy_o=1 in cycles 11-14, rise_o=1 and level_o=1 in cycle 15, glitch_cnt_o=0.
- Glitch rejection: N=5, sig_i high for 2 cycles after re_i, then fe_i. Expect return to S_LOW, no rise_o, glitch_cnt_o=1, level_o stays 0.
- Threshold latch: N=4 at re_i; change cnt_max_i to 100 two cycles later. Expect rise_o exactly at T+6.
- Saturation and clear: GLITCH_W=2, 5 glitches. Expect glitch_cnt_o=3. Assert glitch_clr_i together with a 6th glitch; expect 0.
- Bypass and reset: en_i=0, toggle sig_i. Expect level_o tracks with 1-cycle lag and no pulses. Then set en_i=1, start qualification with N=10, assert rst_i mid-way. Expect all outputs 0 and no rise_o.
- IRQ (macro defined): debounced fall, then irq_clr_i asserted in the same cycle as the next rise_o. Expect irq_o=1 both before and after that cycle (set wins). A lone irq_clr_i afterwards gives irq_o=0. Without the macro, irq_o stays 0 throughout.
